alu_seq: RTL

Registered, handshaked, parametrised successor to the combinational datapath ALU. It latches operands on accept and registers result and flags. It adds logic ops, rotate/arithmetic shift, carry-chained ADC/SBB, and an iterative shift-add multiplier. It sits between the register file buses A/B and the C bus in the processor datapath; the control unit drives sValidIn and waits on sValidOut.

---
 rtl/alu_seq_if.sv | 31 +++
 rtl/alu_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// Handshake and data bus between the control unit / register file buses and
// the sequential ALU. The ALU side uses the slave modport.
interface alu_seq_if #(
    parameter int DATAWIDTH = 8,
    parameter int SELECTION = 4
);
    logic                 sValidIn;
    logic                 sReadyOut;
    logic [SELECTION-1:0] sSelAlu;
    logic [DATAWIDTH-1:0] sDataInBusA;
    logic [DATAWIDTH-1:0] sDataInBusB;
    logic [DATAWIDTH-1:0] sDataOutBusC;
    logic                 sValidOut;
    logic                 sCarry;
    logic                 sOverflow;
    logic                 sNegative;
    logic                 sZero;
    logic                 sPar;

    modport master (
        output sValidIn, sSelAlu, sDataInBusA, sDataInBusB,
        input  sReadyOut, sDataOutBusC, sValidOut,
        input  sCarry, sOverflow, sNegative, sZero, sPar
    );

    modport slave (
        input  sValidIn, sSelAlu, sDataInBusA, sDataInBusB,
        output sReadyOut, sDataOutBusC, sValidOut,
        output sCarry, sOverflow, sNegative, sZero, sPar
    );
endinterface

// File: rtl/alu_seq.sv
// Registered, handshaked ALU. Single-cycle ops complete at the accept edge;
// MULL/MULH run an iterative shift-add multiply, one partial product per cycle.
//
//   state | meaning
//   IDLE  | ready; single-cycle ops accepted and completed each cycle
//   MUL   | shift-add multiply in progress; requests ignored
module alu_seq #(
    parameter int DATAWIDTH = 8,
    parameter int SELECTION = 4
) (
    input  logic     sClk,
    input  logic     sReset,
    alu_seq_if.slave bus
);
    localparam int W  = DATAWIDTH;
    localparam int CW = $clog2(DATAWIDTH + 1);

    localparam logic [SELECTION-1:0] OP_PASSA = SELECTION'(0);
    localparam logic [SELECTION-1:0] OP_SUB   = SELECTION'(1);
    localparam logic [SELECTION-1:0] OP_ADD   = SELECTION'(2);
    localparam logic [SELECTION-1:0] OP_LSR   = SELECTION'(3);
    localparam logic [SELECTION-1:0] OP_LSL   = SELECTION'(4);
    localparam logic [SELECTION-1:0] OP_PASSB = SELECTION'(5);
    localparam logic [SELECTION-1:0] OP_AND   = SELECTION'(6);
    localparam logic [SELECTION-1:0] OP_OR    = SELECTION'(7);
    localparam logic [SELECTION-1:0] OP_XOR   = SELECTION'(8);
    localparam logic [SELECTION-1:0] OP_NOT   = SELECTION'(9);
    localparam logic [SELECTION-1:0] OP_ASR   = SELECTION'(10);
    localparam logic [SELECTION-1:0] OP_ROL   = SELECTION'(11);
    localparam logic [SELECTION-1:0] OP_ADC   = SELECTION'(12);
    localparam logic [SELECTION-1:0] OP_SBB   = SELECTION'(13);
    localparam logic [SELECTION-1:0] OP_MULL  = SELECTION'(14);
    localparam logic [SELECTION-1:0] OP_MULH  = SELECTION'(15);

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   res_q, res_d;
    logic           carry_q, carry_d;
    logic           ovf_q, ovf_d;
    logic           neg_q, neg_d;
    logic           zero_q, zero_d;
    logic           par_q, par_d;
    logic           valid_q, valid_d;
    logic [2*W-1:0] mul_a_q, mul_a_d;
    logic [W-1:0]   mul_b_q, mul_b_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           hi_sel_q, hi_sel_d;

    logic           ready;
    logic           accept;
    logic           is_mul;

    logic [W:0]     a_x, b_x, cin_x, ext_r;
    logic [W-1:0]   alu_res;
    logic           alu_cy, alu_ov;

    logic [2*W-1:0] step_acc;
    logic           wr_en;
    logic [W-1:0]   wr_res;
    logic           wr_cy, wr_ov;

    assign ready  = (state_q == IDLE);
    assign accept = bus.sValidIn & ready;
    assign is_mul = (bus.sSelAlu == OP_MULL) || (bus.sSelAlu == OP_MULH);

    // Single-cycle datapath: result, carry and overflow for the requested opcode.
    // Add/sub run one bit wider so bit W is the carry-out / borrow.
    always_comb begin
        a_x     = {1'b0, bus.sDataInBusA};
        b_x     = {1'b0, bus.sDataInBusB};
        cin_x   = {{W{1'b0}}, ((bus.sSelAlu == OP_ADC) || (bus.sSelAlu == OP_SBB)) & carry_q};
        ext_r   = '0;
        alu_res = bus.sDataInBusA;
        alu_cy  = 1'b0;
        alu_ov  = 1'b0;
        case (bus.sSelAlu)
            OP_PASSA: alu_res = bus.sDataInBusA;
            OP_SUB, OP_SBB: begin
                ext_r   = a_x - b_x - cin_x;
                alu_res = ext_r[W-1:0];
                alu_cy  = ext_r[W];
                alu_ov  = (bus.sDataInBusA[W-1] != bus.sDataInBusB[W-1]) &&
                          (ext_r[W-1] != bus.sDataInBusA[W-1]);
            end
            OP_ADD, OP_ADC: begin
                ext_r   = a_x + b_x + cin_x;
                alu_res = ext_r[W-1:0];
                alu_cy  = ext_r[W];
                alu_ov  = (bus.sDataInBusA[W-1] == bus.sDataInBusB[W-1]) &&
                          (ext_r[W-1] != bus.sDataInBusA[W-1]);
            end
            OP_LSR: begin
                alu_res = {1'b0, bus.sDataInBusA[W-1:1]};
                alu_cy  = bus.sDataInBusA[0];
            end
            OP_LSL: begin
                alu_res = {bus.sDataInBusA[W-2:0], 1'b0};
                alu_cy  = bus.sDataInBusA[W-1];
            end
            OP_PASSB: alu_res = bus.sDataInBusB;
            OP_AND:   alu_res = bus.sDataInBusA & bus.sDataInBusB;
            OP_OR:    alu_res = bus.sDataInBusA | bus.sDataInBusB;
            OP_XOR:   alu_res = bus.sDataInBusA ^ bus.sDataInBusB;
            OP_NOT:   alu_res = ~bus.sDataInBusA;
            OP_ASR: begin
                alu_res = {bus.sDataInBusA[W-1], bus.sDataInBusA[W-1:1]};
                alu_cy  = bus.sDataInBusA[0];
            end
            OP_ROL: begin
                alu_res = {bus.sDataInBusA[W-2:0], bus.sDataInBusA[W-1]};
                alu_cy  = bus.sDataInBusA[W-1];
            end
            default: alu_res = bus.sDataInBusA;
        endcase
    end

    // FSM next state, multiplier stepping and result/flag write-back.
    // The last shift-add step and the write share one edge, giving a
    // W+1 cycle accept-to-valid latency for multiplies.
    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        neg_d    = neg_q;
        zero_d   = zero_q;
        par_d    = par_q;
        valid_d  = 1'b0;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        hi_sel_d = hi_sel_q;
        step_acc = acc_q + (mul_b_q[0] ? mul_a_q : '0);
        wr_en    = 1'b0;
        wr_res   = '0;
        wr_cy    = 1'b0;
        wr_ov    = 1'b0;

        if (state_q == IDLE) begin
            if (accept) begin
                if (is_mul) begin
                    mul_a_d  = {{W{1'b0}}, bus.sDataInBusA};
                    mul_b_d  = bus.sDataInBusB;
                    acc_d    = '0;
                    cnt_d    = CW'(W);
                    hi_sel_d = (bus.sSelAlu == OP_MULH);
                    state_d  = MUL;
                end else begin
                    wr_en  = 1'b1;
                    wr_res = alu_res;
                    wr_cy  = alu_cy;
                    wr_ov  = alu_ov;
                end
            end
        end else begin
            acc_d   = step_acc;
            mul_a_d = mul_a_q << 1;
            mul_b_d = mul_b_q >> 1;
            cnt_d   = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                wr_en   = 1'b1;
                wr_res  = hi_sel_q ? step_acc[2*W-1:W] : step_acc[W-1:0];
                wr_cy   = (step_acc[2*W-1:W] != '0);
                wr_ov   = (step_acc[2*W-1:W] != '0);
                state_d = IDLE;
            end
        end

        if (wr_en) begin
            res_d   = wr_res;
            carry_d = wr_cy;
            ovf_d   = wr_ov;
            neg_d   = wr_res[W-1];
            zero_d  = (wr_res == '0);
            par_d   = ~wr_res[0];
            valid_d = 1'b1;
        end
    end

    // State, result, flag and multiplier registers.
    always_ff @(posedge sClk or posedge sReset) begin
        if (sReset) begin
            state_q  <= IDLE;
            res_q    <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            par_q    <= 1'b0;
            valid_q  <= 1'b0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            hi_sel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            neg_q    <= neg_d;
            zero_q   <= zero_d;
            par_q    <= par_d;
            valid_q  <= valid_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            hi_sel_q <= hi_sel_d;
        end
    end

    assign bus.sReadyOut    = ready;
    assign bus.sValidOut    = valid_q;
    assign bus.sDataOutBusC = res_q;
    assign bus.sCarry       = carry_q;
    assign bus.sOverflow    = ovf_q;
    assign bus.sNegative    = neg_q;
    assign bus.sZero        = zero_q;
    assign bus.sPar         = par_q;
endmodule
